aipp_tx_framer: RTL

- Transmit side of the AIPP pre-charge protocol.
- Accepts pre-charge requests (delay, voltage) from the scheduler over a valid/ready interface and range-checks them.
- Assembles the 128-bit AIPP header and streams it LSB-first to the link in BEAT_W-bit beats with valid/ready backpressure.
- The far-end header parser consumes the reassembled 128-bit header.

---
 rtl/aipp_pkg.sv | 42 ++++
 rtl/aipp_tx_framer_if.sv | 29 ++
 rtl/aipp_hdr_pack.sv | 25 ++
 rtl/aipp_tx_framer.sv | 118 +++++++++++
 4 files changed

// File: rtl/aipp_pkg.sv
// Shared AIPP definitions, used by both the transmit framer and the far-end
// header parser.
//   HDR_W / field offsets : 128-bit pre-charge header layout
//   OPC_PRECHARGE         : opcode placed in header byte 0
//   aipp_hdr_t            : packed view of the header (bit 0 = opcode LSB)
//   hdr_csum()            : XOR of the bytes below the checksum field
package aipp_pkg;

    localparam int unsigned HDR_W         = 128;
    localparam logic [7:0]  OPC_PRECHARGE = 8'h10;

    localparam int unsigned OPC_LSB   = 0;
    localparam int unsigned DELAY_LSB = 8;
    localparam int unsigned VOLT_LSB  = 40;
    localparam int unsigned SEQ_LSB   = 72;
    localparam int unsigned CSUM_LSB  = 80;

    localparam int unsigned OPC_W   = 8;
    localparam int unsigned DELAY_W = 32;
    localparam int unsigned VOLT_W  = 32;
    localparam int unsigned SEQ_W   = 8;
    localparam int unsigned CSUM_W  = 8;

    typedef struct packed {
        logic [HDR_W-CSUM_LSB-CSUM_W-1:0] rsvd;
        logic [CSUM_W-1:0]                csum;
        logic [SEQ_W-1:0]                 seq;
        logic [VOLT_W-1:0]                voltage_mv;
        logic [DELAY_W-1:0]               delay_us;
        logic [OPC_W-1:0]                 opcode;
    } aipp_hdr_t;

    function automatic logic [CSUM_W-1:0] hdr_csum(input logic [CSUM_LSB-1:0] body);
        logic [CSUM_W-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < CSUM_LSB / 8; i++) begin
            acc ^= body[i*8 +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/aipp_tx_framer_if.sv
// Scheduler-request and link-beat channels of the AIPP transmit framer.
//   req_*  : pre-charge request (valid/ready) plus one-cycle reject pulse
//   tx_*   : header beats to the link (valid/ready), tx_last on final beat
// Modports:
//   master : the framer (accepts requests, drives beats)
//   slave  : the environment (scheduler and link)
interface aipp_tx_framer_if #(
    parameter int unsigned BEAT_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_delay_us;
    logic [31:0]       req_voltage_mv;
    logic              req_err;
    logic              tx_valid;
    logic              tx_ready;
    logic [BEAT_W-1:0] tx_data;
    logic              tx_last;

    modport master (
        input  req_valid, req_delay_us, req_voltage_mv, tx_ready,
        output req_ready, req_err, tx_valid, tx_data, tx_last
    );

    modport slave (
        output req_valid, req_delay_us, req_voltage_mv, tx_ready,
        input  req_ready, req_err, tx_valid, tx_data, tx_last
    );
endinterface

// File: rtl/aipp_hdr_pack.sv
// Combinational AIPP header packer.
//   opcode, delay_us, voltage_mv, seq : header fields
//   hdr                               : 128-bit header with checksum byte
//                                       and zeroed reserved bits
module aipp_hdr_pack
    import aipp_pkg::*;
(
    input  logic [OPC_W-1:0]   opcode,
    input  logic [DELAY_W-1:0] delay_us,
    input  logic [VOLT_W-1:0]  voltage_mv,
    input  logic [SEQ_W-1:0]   seq,
    output aipp_hdr_t          hdr
);
    logic [HDR_W-1:0] word;

    always_comb begin
        word = '0;
        word[OPC_LSB   +: OPC_W]   = opcode;
        word[DELAY_LSB +: DELAY_W] = delay_us;
        word[VOLT_LSB  +: VOLT_W]  = voltage_mv;
        word[SEQ_LSB   +: SEQ_W]   = seq;
        word[CSUM_LSB  +: CSUM_W]  = hdr_csum(word[CSUM_LSB-1:0]);
        hdr = aipp_hdr_t'(word);
    end
endmodule

// File: rtl/aipp_tx_framer.sv
// AIPP pre-charge transmit framer.
// Accepts range-checked pre-charge requests, builds the 128-bit header and
// streams it LSB-first as HDR_W/BEAT_W beats with valid/ready backpressure.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request and beat channels (aipp_tx_framer_if.master)
//   seq_num    : sequence number the next legal request will carry
//   busy       : a frame is in flight
// All outputs are registered; tx_ready only affects next-state logic.
module aipp_tx_framer
    import aipp_pkg::*;
#(
    parameter int unsigned BEAT_W         = 32,
    parameter int unsigned MAX_DELAY_US   = 1000000,
    parameter int unsigned MAX_VOLTAGE_MV = 1500
) (
    input  logic              clk,
    input  logic              rst_n,
    aipp_tx_framer_if.master  bus,
    output logic [7:0]        seq_num,
    output logic              busy
);
    localparam int unsigned NUM_BEATS = HDR_W / BEAT_W;
    localparam int unsigned IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);
    localparam logic [31:0] MAX_D = 32'(MAX_DELAY_US);
    localparam logic [31:0] MAX_V = 32'(MAX_VOLTAGE_MV);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } tx_state_e;

    tx_state_e        state;
    logic [IDX_W-1:0] beat_idx;
    logic [HDR_W-1:0] shreg;
    logic [7:0]       seq_q;
    logic             ready_q;
    logic             err_q;
    logic             valid_q;
    logic             last_q;
    logic             busy_q;
    aipp_hdr_t        hdr_next;
    logic             legal;

    aipp_hdr_pack u_pack (
        .opcode     (OPC_PRECHARGE),
        .delay_us   (bus.req_delay_us),
        .voltage_mv (bus.req_voltage_mv),
        .seq        (seq_q),
        .hdr        (hdr_next)
    );

    assign legal = (bus.req_delay_us <= MAX_D) && (bus.req_voltage_mv <= MAX_V);

    // The header sits in a right-shifting register, so the current beat is
    // always its low BEAT_W bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            beat_idx <= '0;
            shreg    <= '0;
            seq_q    <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (ready_q && bus.req_valid) begin
                        if (legal) begin
                            state    <= ST_SEND;
                            ready_q  <= 1'b0;
                            valid_q  <= 1'b1;
                            busy_q   <= 1'b1;
                            last_q   <= (LAST_IDX == '0);
                            shreg    <= hdr_next;
                            beat_idx <= '0;
                            seq_q    <= seq_q + 8'd1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    // valid_q is held high for the whole SEND state.
                    if (bus.tx_ready) begin
                        if (last_q) begin
                            state    <= ST_IDLE;
                            ready_q  <= 1'b1;
                            valid_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            last_q   <= 1'b0;
                            shreg    <= '0;
                            beat_idx <= '0;
                        end else begin
                            beat_idx <= beat_idx + IDX_W'(1);
                            shreg    <= shreg >> BEAT_W;
                            last_q   <= ((beat_idx + IDX_W'(1)) == LAST_IDX);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.req_err   = err_q;
    assign bus.tx_valid  = valid_q;
    assign bus.tx_last   = last_q;
    assign bus.tx_data   = shreg[BEAT_W-1:0];
    assign seq_num       = seq_q;
    assign busy          = busy_q;
endmodule
